// File: rtl/flap_sequencer.sv
// Request arbiter and step sequencer in front of the flap indicator core.
// Turns granted targets into spaced step pulses and manages cyclic mode entry, exit and re-homing.
module flap_sequencer #(
  parameter int POSITIONS   = 10,
  parameter int POS_W       = 4,
  parameter int STEP_GAP    = 4,
  parameter int IDLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic [1:0]         req_valid,
  input  logic [2*POS_W-1:0] req_target,
  output logic [1:0]         req_ready,
  input  logic               home_sense,
  output logic               change_position_re,
  output logic               change_mode_re,
  output logic [POS_W-1:0]   current_pos,
  output logic               busy,
  output logic               cyclic_active,
  output logic               done,
  output logic               err
);

  localparam int GAP_W  = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(STEP_GAP - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(POSITIONS - 1);
  localparam logic [POS_W-1:0]   POS_MOD   = POS_W'(POSITIONS);
  localparam logic [POS_W:0]     POS_LIMIT = (POS_W+1)'(POSITIONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_GAP,
    S_DONE,
    S_CYCLIC,
    S_EXIT,
    S_HOME_STEP,
    S_HOME_GAP
  } state_t;

  state_t             state_q;
  logic [POS_W-1:0]   pos_q;
  logic [POS_W-1:0]   rem_q;
  logic [GAP_W-1:0]   gap_q;
  logic [POS_W:0]     home_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic               last_q;
  logic               step_q;
  logic               mode_q;
  logic               cyc_q;
  logic               done_q;
  logic               err_q;

  logic [1:0]         gnt_d;
  logic [POS_W-1:0]   tgt_d;
  logic [POS_W-1:0]   steps_d;
  logic               bad_d;
  logic               idle_hit_d;

  // Arbitration is combinational so the accept lands in the same IDLE cycle as the request
  always_comb begin
    gnt_d = 2'b00;
    if (state_q == S_IDLE && !async_reset) begin
      if (req_valid == 2'b11) gnt_d = last_q ? 2'b01 : 2'b10;
      else                    gnt_d = req_valid;
    end
    tgt_d = gnt_d[1] ? req_target[POS_W +: POS_W] : req_target[0 +: POS_W];
    bad_d = {1'b0, tgt_d} >= POS_LIMIT;
    // Forward distance modulo POSITIONS; fits POS_W bits since it is below POSITIONS
    if (tgt_d >= pos_q) steps_d = tgt_d - pos_q;
    else                steps_d = tgt_d + POS_MOD - pos_q;
    idle_hit_d = (IDLE_CYCLES != 0) && (state_q == S_IDLE) &&
                 (req_valid == 2'b00) && (idle_cnt_q == IDLE_LAST);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      home_cnt_q <= '0;
      idle_cnt_q <= '0;
      last_q     <= 1'b1;
      step_q     <= 1'b0;
      mode_q     <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      step_q <= 1'b0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != S_IDLE) idle_cnt_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (|gnt_d) begin
            last_q     <= gnt_d[1];
            idle_cnt_q <= '0;
            if (bad_d) begin
              err_q <= 1'b1;
            end else if (steps_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              rem_q   <= steps_d;
              state_q <= S_STEP;
              step_q  <= 1'b1;
            end
          end else if (idle_hit_d) begin
            idle_cnt_q <= '0;
            gap_q      <= GAP_LOAD;
            state_q    <= S_CYCLIC;
            mode_q     <= 1'b1;
          end else if (IDLE_CYCLES != 0) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end

        S_STEP: begin
          pos_q   <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          rem_q   <= rem_q - 1'b1;
          gap_q   <= GAP_LOAD;
          state_q <= S_GAP;
        end

        S_GAP: begin
          if (gap_q == GAP_W'(1)) begin
            if (rem_q == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_STEP;
              step_q  <= 1'b1;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        S_DONE: state_q <= S_IDLE;

        // Exit is held off until the mode pulse has settled, keeping pulse spacing intact
        S_CYCLIC: begin
          cyc_q <= 1'b1;
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else if (|req_valid) begin
            state_q <= S_EXIT;
            mode_q  <= 1'b1;
          end
        end

        S_EXIT: begin
          cyc_q      <= 1'b0;
          gap_q      <= GAP_LOAD;
          home_cnt_q <= '0;
          state_q    <= S_HOME_GAP;
        end

        S_HOME_GAP: begin
          if (gap_q == GAP_W'(1)) begin
            if (home_sense) begin
              pos_q   <= '0;
              state_q <= S_IDLE;
            end else if (home_cnt_q == POS_LIMIT) begin
              pos_q   <= '0;
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOME_STEP;
              step_q  <= 1'b1;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        S_HOME_STEP: begin
          home_cnt_q <= home_cnt_q + 1'b1;
          gap_q      <= GAP_LOAD;
          state_q    <= S_HOME_GAP;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready          = gnt_d;
  assign change_position_re = step_q;
  assign change_mode_re     = mode_q;
  assign current_pos        = pos_q;
  assign busy               = (state_q != S_IDLE);
  assign cyclic_active      = cyc_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_flap_sequencer.sv
// Directed bench for flap_sequencer: arbitration, step timing, cyclic entry/exit, homing and reset.
module tb_flap_sequencer;

  localparam int STEP_GAP = 4;

  logic       clk = 1'b0;
  logic       async_reset;
  logic [1:0] req_valid;
  logic [7:0] req_target;
  logic [1:0] req_ready;
  logic       home_sense;
  logic       change_position_re;
  logic       change_mode_re;
  logic [3:0] current_pos;
  logic       busy;
  logic       cyclic_active;
  logic       done;
  logic       err;

  int n_pass = 0;
  int n_total = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int last_pulse = -1;

  flap_sequencer #(
    .POSITIONS(10), .POS_W(4), .STEP_GAP(STEP_GAP), .IDLE_CYCLES(64)
  ) dut (
    .clk(clk), .async_reset(async_reset), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .home_sense(home_sense), .change_position_re(change_position_re),
    .change_mode_re(change_mode_re), .current_pos(current_pos), .busy(busy),
    .cyclic_active(cyclic_active), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse bookkeeping, exclusivity and spacing, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!async_reset && (change_position_re || change_mode_re)) begin
      if (change_position_re) pulse_cnt++;
      check("pulse_exclusive", {31'd0, change_position_re & change_mode_re}, 0);
      if (last_pulse >= 0) check("pulse_spacing", {31'd0, (cyc - last_pulse) >= STEP_GAP}, 1);
      last_pulse = cyc;
    end
  end

  task automatic request(input int idx, input int tgt, input logic [1:0] exp_ready, input string tag);
    req_target[idx*4 +: 4] = tgt[3:0];
    req_valid[idx] = 1'b1;
    #1;
    check({tag, "_ready"}, {30'd0, req_ready}, {30'd0, exp_ready});
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound, output int pulses);
    int p0 = pulse_cnt;
    int n = 0;
    while (!(done || err) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, {31'd0, done | err}, 1);
    pulses = pulse_cnt - p0;
  endtask

  initial begin
    int np;
    int n;
    int hp;
    async_reset = 1'b1;
    req_valid   = 2'b00;
    req_target  = 8'd0;
    home_sense  = 1'b0;
    #2;
    check("rst_pulse", {31'd0, change_position_re}, 0);
    check("rst_mode", {31'd0, change_mode_re}, 0);
    check("rst_pos", {28'd0, current_pos}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_flags", {28'd0, cyclic_active, done, err, 1'b0}, 0);
    check("rst_ready", {30'd0, req_ready}, 0);
    tick();
    tick();
    async_reset = 1'b0;
    tick();

    // Target 3 from 0: pulses at T+1, T+5, T+9, done at T+13
    request(0, 3, 2'b01, "t3");
    for (int i = 1; i <= 13; i++) begin
      check($sformatf("t3_pulse_%0d", i), {31'd0, change_position_re},
            {31'd0, (i == 1 || i == 5 || i == 9)});
      check($sformatf("t3_done_%0d", i), {31'd0, done}, {31'd0, i == 13});
      if (i == 2) check("t3_pos_after_first", {28'd0, current_pos}, 1);
      if (i == 13) check("t3_pos_done", {28'd0, current_pos}, 3);
      tick();
    end
    check("t3_idle_busy", {31'd0, busy}, 0);

    request(0, 8, 2'b01, "t8");
    wait_end("t8", 100, np);
    check("t8_pulses", np, 5);
    check("t8_pos", {28'd0, current_pos}, 8);
    tick();

    // Wrap-around: 8 -> 9 -> 0 -> 1 -> 2 via requester 1
    request(1, 2, 2'b10, "t2");
    wait_end("t2", 100, np);
    check("t2_pulses", np, 4);
    check("t2_pos", {28'd0, current_pos}, 2);
    tick();

    // Both valid, last grant went to requester 1, so requester 0 wins
    req_target = {4'd7, 4'd5};
    req_valid  = 2'b11;
    #1;
    check("rr_first_ready", {30'd0, req_ready}, 2'b01);
    tick();
    req_valid = 2'b10;
    check("rr_busy_ready", {30'd0, req_ready}, 0);
    wait_end("rr5", 100, np);
    check("rr5_pulses", np, 3);
    check("rr5_pos", {28'd0, current_pos}, 5);
    check("rr_done_ready", {30'd0, req_ready}, 0);
    tick();
    check("rr_second_ready", {30'd0, req_ready}, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_end("rr7", 100, np);
    check("rr7_pulses", np, 2);
    check("rr7_pos", {28'd0, current_pos}, 7);
    tick();

    // Out-of-range target: error, no movement
    request(0, 12, 2'b01, "bad");
    check("bad_err", {31'd0, err}, 1);
    check("bad_busy", {31'd0, busy}, 0);
    wait_end("bad", 10, np);
    check("bad_pulses", np, 0);
    check("bad_pos", {28'd0, current_pos}, 7);
    tick();
    check("bad_err_one_cycle", {31'd0, err}, 0);

    // Target equals current position: immediate done
    request(0, 7, 2'b01, "same");
    check("same_done", {31'd0, done}, 1);
    wait_end("same", 10, np);
    check("same_pulses", np, 0);

    // 64 idle cycles after the done cycle, mode pulse on the 65th
    n = 0;
    while (!change_mode_re && n < 200) begin
      tick();
      n++;
    end
    check("cyc_entry_delay", n, 65);
    check("cyc_active_at_pulse", {31'd0, cyclic_active}, 0);
    tick();
    check("cyc_active", {31'd0, cyclic_active}, 1);
    check("cyc_busy", {31'd0, busy}, 1);
    check("cyc_pos_held", {28'd0, current_pos}, 7);
    repeat (4) tick();
    req_target[3:0] = 4'd4;
    req_valid = 2'b01;
    #1;
    check("cyc_no_ready", {30'd0, req_ready}, 0);
    tick();
    check("exit_mode", {31'd0, change_mode_re}, 1);
    tick();
    check("exit_cyc_clear", {31'd0, cyclic_active}, 0);
    hp = 0;
    n = 0;
    while (req_ready != 2'b01 && n < 100) begin
      tick();
      n++;
      if (change_position_re) begin
        hp++;
        if (hp == 2) home_sense = 1'b1;
      end
    end
    check("home_accept", {30'd0, req_ready}, 2'b01);
    check("home_pulses", hp, 2);
    check("home_pos", {28'd0, current_pos}, 0);
    tick();
    req_valid  = 2'b00;
    home_sense = 1'b0;
    wait_end("after_home", 100, np);
    check("after_home_pulses", np, 4);
    check("after_home_pos", {28'd0, current_pos}, 4);

    // Homing failure with home_sense stuck low
    n = 0;
    while (!change_mode_re && n < 200) begin
      tick();
      n++;
    end
    check("cyc2_entry", {31'd0, change_mode_re}, 1);
    repeat (5) tick();
    req_target[3:0] = 4'd0;
    req_valid = 2'b01;
    np = pulse_cnt;
    n = 0;
    while (!err && n < 300) begin
      tick();
      n++;
    end
    check("hfail_err", {31'd0, err}, 1);
    check("hfail_pulses", pulse_cnt - np, 10);
    check("hfail_pos", {28'd0, current_pos}, 0);
    check("hfail_ready", {30'd0, req_ready}, 2'b01);
    tick();
    req_valid = 2'b00;
    check("hfail_req_done", {31'd0, done}, 1);
    check("hfail_req_nopulse", {31'd0, change_position_re}, 0);
    tick();

    // Reset asserted during the second step pulse
    request(0, 5, 2'b01, "rst_mid");
    n = 0;
    while (!(change_position_re && current_pos == 4'd1) && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_reached", {31'd0, change_position_re}, 1);
    req_valid = 2'b01;
    async_reset = 1'b1;
    #1;
    check("rst_mid_pulse", {31'd0, change_position_re}, 0);
    check("rst_mid_pos", {28'd0, current_pos}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_ready", {30'd0, req_ready}, 0);
    check("rst_mid_flags", {28'd0, change_mode_re, cyclic_active, done, err}, 0);
    tick();
    check("rst_hold_pulse", {31'd0, change_position_re}, 0);
    req_valid = 2'b00;
    async_reset = 1'b0;
    tick();
    check("rst_release_busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
